ac_bit_packer: RTL and testbench

- Downstream stage of the arithmetic encoder.
- Collects the encoder's serial code bits MSB-first into bytes and buffers them in a small FIFO.
- Presents the bytes on a valid/ready byte stream with an end-of-frame marker.
- On terminate, flushes the partial last byte zero-padded and reports its valid-bit count and the frame's total bit count.

---
 rtl/ac_pkg.sv | 21 ++
 rtl/ac_byte_fifo.sv | 54 +++++
 rtl/ac_bit_packer.sv | 147 ++++++++++++++
 tb/tb_ac_bit_packer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared types for the arithmetic-coder back end: packer FSM states and the
// default output FIFO entry layout.
package ac_pkg;

  localparam int unsigned DefaultByteW  = 8;
  localparam int unsigned DefaultNbitsW = $clog2(DefaultByteW) + 1;

  typedef enum logic [1:0] {
    StPack,
    StFlush,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [DefaultByteW-1:0]  data;
    logic [DefaultNbitsW-1:0] nbits;
    logic                     last;
  } entry_t;

endpackage

// File: rtl/ac_byte_fifo.sv
// Show-ahead FIFO with full/empty flags; a push into a full FIFO is taken only
// when a pop happens on the same edge.
module ac_byte_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign rdata_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ac_bit_packer.sv
// Packs serial code bits MSB-first into bytes, buffers them and flushes a
// zero-padded tail entry marked last when the encoder terminates a frame.
module ac_bit_packer
  import ac_pkg::*;
#(
  parameter int unsigned BYTE_W     = DefaultByteW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned NbW       = $clog2(BYTE_W) + 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              terminate_in,
  output logic              in_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic [NbW-1:0]    byte_nbits,
  output logic [CNT_W-1:0]  total_bits,
  output logic              done,
  output logic              overflow
);

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [NbW-1:0]    nbits;
    logic              last;
  } byte_entry_t;

  localparam logic [NbW-1:0] NbFull    = NbW'(BYTE_W);
  localparam logic [NbW-1:0] NbLastBit = NbW'(BYTE_W - 1);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [NbW-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              done_q, done_d, ovf_q, ovf_d;
  logic              fifo_full, fifo_empty, push, pop, accept;
  byte_entry_t       push_entry, head_entry;

  // Held low during reset so every output reads 0; in DONE a new bit restarts the frame.
  assign in_ready = sys_reset &&
                    (((state_q == StPack) && !(fifo_full && (pend_q == NbLastBit))) ||
                     (state_q == StDone));
  assign accept   = bit_valid && in_ready;
  assign pop      = !fifo_empty && byte_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    total_d    = total_q;
    done_d     = done_q;
    ovf_d      = ovf_q | (bit_valid & ~in_ready);
    push       = 1'b0;
    push_entry = '0;

    if (accept) begin
      shift_d = {shift_q[BYTE_W-2:0], bit_in};
      if (state_q == StDone) begin
        state_d = StPack;
        done_d  = 1'b0;
        total_d = CNT_W'(1);
        pend_d  = NbW'(1);
      end else begin
        total_d = (&total_q) ? total_q : total_q + 1'b1;
        if (pend_q == NbLastBit) begin
          push       = 1'b1;
          push_entry = '{data: shift_d, nbits: NbFull, last: 1'b0};
          pend_d     = '0;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
    end

    unique case (state_q)
      StPack: begin
        if (terminate_in) state_d = StFlush;
      end
      StFlush: begin
        if (!fifo_full) begin
          push             = 1'b1;
          push_entry.data  = (pend_q == '0) ? '0 : shift_q << (NbFull - pend_q);
          push_entry.nbits = pend_q;
          push_entry.last  = 1'b1;
          shift_d          = '0;
          pend_d           = '0;
          state_d          = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_entry.last) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
      end
      default: state_d = StPack;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= StPack;
      shift_q <= '0;
      pend_q  <= '0;
      total_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      total_q <= total_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  ac_byte_fifo #(
    .Width($bits(byte_entry_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (sys_clk),
    .rst_ni (sys_reset),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign byte_valid = !fifo_empty;
  assign byte_out   = head_entry.data;
  assign byte_nbits = head_entry.nbits;
  assign byte_last  = head_entry.last;
  assign total_bits = total_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ac_bit_packer.sv
// Bench for ac_bit_packer: directed scenarios plus random back-to-back frames,
// checked against a bit-list model of the expected byte stream.
module tb_ac_bit_packer;

  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 6;
  localparam int unsigned NBW   = $clog2(BW) + 1;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic           sys_clk = 1'b0, sys_reset = 1'b0;
  logic           bit_in = 1'b0, bit_valid = 1'b0, terminate_in = 1'b0;
  logic           fixed_ready = 1'b0, rand_ready = 1'b0, rand_mode = 1'b0;
  logic           byte_ready;
  logic           in_ready, byte_valid, byte_last, done, overflow;
  logic [BW-1:0]  byte_out;
  logic [NBW-1:0] byte_nbits;
  logic [CW-1:0]  total_bits;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          got_base = 0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  bit          stim_q[$];

  assign byte_ready = rand_mode ? rand_ready : fixed_ready;

  ac_bit_packer #(
    .BYTE_W    (BW),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .terminate_in(terminate_in),
    .in_ready    (in_ready),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_last   (byte_last),
    .byte_nbits  (byte_nbits),
    .total_bits  (total_bits),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) rand_ready = 1'($urandom_range(0, 1));

  // Every handshaken byte, as {last, nbits, data}.
  always @(posedge sys_clk) begin
    if (sys_reset && byte_valid && byte_ready) got_q.push_back({byte_last, byte_nbits, byte_out});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_reset    = 1'b0;
    bit_valid    = 1'b0;
    terminate_in = 1'b0;
    fixed_ready  = 1'b0;
    rand_mode    = 1'b0;
    step();
    sys_reset = 1'b1;
    step();
    stim_q.delete();
    got_base = got_q.size();
  endtask

  task automatic send_bit(input logic b, input logic term);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_bit_timeout: in_ready=%b, required 1", in_ready);
    end
    stim_q.push_back(b);
    bit_in       = b;
    bit_valid    = 1'b1;
    terminate_in = term;
    step();
    bit_valid    = 1'b0;
    terminate_in = 1'b0;
  endtask

  task automatic send_term();
    terminate_in = 1'b1;
    step();
    terminate_in = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 400) begin
      step();
      guard++;
    end
  endtask

  // Expected entries: whole bytes MSB-first, then a left-aligned tail marked last.
  task automatic build_model();
    int n = stim_q.size();
    int v;
    exp_q.delete();
    for (int i = 0; i < n / 8; i++) begin
      v = 0;
      for (int j = 0; j < 8; j++) v = v * 2 + int'(stim_q[8 * i + j]);
      exp_q.push_back({1'b0, 4'd8, 8'(v)});
    end
    v = 0;
    for (int j = 0; j < n % 8; j++) v = v * 2 + int'(stim_q[(n / 8) * 8 + j]);
    if (n % 8 != 0) v = v << (8 - n % 8);
    exp_q.push_back({1'b1, 4'(n % 8), 8'(v)});
  endtask

  task automatic test_reset();
    sys_reset = 1'b0;
    step();
    n_checks++;
    if ({in_ready, byte_valid, byte_last, done, overflow, byte_out, byte_nbits, total_bits} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {in_ready, byte_valid, byte_last, done, overflow, byte_out, byte_nbits, total_bits});
    end
    sys_reset = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b byte_valid=%b, required 1 0", in_ready, byte_valid);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] pat = 8'hB2;
    do_reset();
    fixed_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        n_checks++;
        if (byte_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: byte_valid=%b before 8th bit, required 0", byte_valid);
        end
      end
      send_bit(pat[i], 1'b0);
    end
    n_checks++;
    if ({byte_valid, byte_last, byte_nbits, byte_out} !== {1'b1, 1'b0, 4'd8, 8'hB2}) begin
      n_fail++;
      $display("FAIL single_byte: valid=%b last=%b nbits=%0d data=%h, required 1 0 8 b2",
               byte_valid, byte_last, byte_nbits, byte_out);
    end
  endtask

  task automatic test_partial_flush();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_term();
    wait_done();
    build_model();
    n_checks++;
    if (done !== 1'b1 || total_bits !== 6'd11 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_flush_end: done=%b total=%0d valid=%b, required 1 11 0",
               done, total_bits, byte_valid);
    end
    n_checks++;
    if (got_q.size() - got_base != exp_q.size()) begin
      n_fail++;
      $display("FAIL partial_flush_count: got %0d entries, required %0d",
               got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL partial_flush_entry[%0d]: got %h, required %h", i, got_q[got_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_tail();
    logic [15:0] pat = 16'hFF01;
    do_reset();
    fixed_ready = 1'b1;
    for (int i = 15; i >= 0; i--) send_bit(pat[i], 1'b0);
    send_term();
    wait_done();
    build_model();
    n_checks++;
    if (done !== 1'b1 || total_bits !== 6'd16) begin
      n_fail++;
      $display("FAIL empty_tail_end: done=%b total=%0d, required 1 16", done, total_bits);
    end
    n_checks++;
    if (got_q.size() - got_base != 3) begin
      n_fail++;
      $display("FAIL empty_tail_count: got %0d entries, required 3", got_q.size() - got_base);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL empty_tail_entry[%0d]: got %h, required %h", i, got_q[got_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b = 1'($urandom_range(0, 1));
      n_checks++;
      if (in_ready !== (i < 39)) begin
        n_fail++;
        $display("FAIL bp_in_ready[%0d]: got %b, required %b", i, in_ready, (i < 39));
      end
      if (i == 39) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_overflow_early: got %b, required 0", overflow);
        end
      end
      if (i < 39) stim_q.push_back(b);
      bit_in    = b;
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || byte_valid !== 1'b1 || total_bits !== 6'd39) begin
      n_fail++;
      $display("FAIL bp_full: overflow=%b valid=%b total=%0d, required 1 1 39",
               overflow, byte_valid, total_bits);
    end
    fixed_ready = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_recover: in_ready=%b after first pop, required 1", in_ready);
    end
    repeat (4) step();
    send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_term();
    wait_done();
    build_model();
    n_checks++;
    if (done !== 1'b1 || overflow !== 1'b1 || total_bits !== 6'd40) begin
      n_fail++;
      $display("FAIL bp_end: done=%b overflow=%b total=%0d, required 1 1 40",
               done, overflow, total_bits);
    end
    n_checks++;
    if (got_q.size() - got_base != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d entries, required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_entry[%0d]: got %h, required %h", i, got_q[got_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_term_on_byte();
    logic [7:0] pat = 8'($urandom_range(0, 255));
    do_reset();
    fixed_ready = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(pat[i], 1'b0);
    send_bit(pat[0], 1'b1);
    wait_done();
    build_model();
    n_checks++;
    if (done !== 1'b1 || total_bits !== 6'd8) begin
      n_fail++;
      $display("FAIL term_byte_end: done=%b total=%0d, required 1 8", done, total_bits);
    end
    n_checks++;
    if (got_q.size() - got_base != 2) begin
      n_fail++;
      $display("FAIL term_byte_count: got %0d entries, required 2", got_q.size() - got_base);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL term_byte_entry[%0d]: got %h, required %h", i, got_q[got_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    n_checks++;
    if (byte_valid !== 1'b1 || total_bits !== 6'd13) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%b total=%0d, required 1 13", byte_valid, total_bits);
    end
    sys_reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, byte_valid, byte_last, done, overflow, byte_out, byte_nbits, total_bits} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {in_ready, byte_valid, byte_last, done, overflow, byte_out, byte_nbits, total_bits});
    end
    step();
    sys_reset = 1'b1;
    step();
    stim_q.delete();
    got_base    = got_q.size();
    fixed_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_term();
    wait_done();
    build_model();
    n_checks++;
    if (got_q.size() - got_base != 2 || total_bits !== 6'd8) begin
      n_fail++;
      $display("FAIL mid_after: entries=%0d total=%0d, required 2 8", got_q.size() - got_base, total_bits);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_entry[%0d]: got %h, required %h", i, got_q[got_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    int exp_total;
    logic term_with_last;
    do_reset();
    rand_mode = 1'b1;
    for (int f = 0; f < 5; f++) begin
      len = (f == 0) ? 0 : ((f == 4) ? 70 : int'($urandom_range(1, 30)));
      term_with_last = (len > 0) && ($urandom_range(0, 1) == 1);
      stim_q.delete();
      got_base = got_q.size();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send_bit(1'($urandom_range(0, 1)), term_with_last && (i == len - 1));
        if (f > 0 && i == 0) begin
          n_checks++;
          if (done !== 1'b0 || total_bits !== 6'd1) begin
            n_fail++;
            $display("FAIL b2b_restart[%0d]: done=%b total=%0d, required 0 1", f, done, total_bits);
          end
        end
      end
      if (!term_with_last) send_term();
      wait_done();
      build_model();
      exp_total = (len > int'(SAT)) ? int'(SAT) : len;
      n_checks++;
      if (done !== 1'b1 || total_bits !== 6'(exp_total)) begin
        n_fail++;
        $display("FAIL b2b_end[%0d]: done=%b total=%0d, required 1 %0d", f, done, total_bits, exp_total);
      end
      n_checks++;
      if (got_q.size() - got_base != exp_q.size()) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: got %0d entries, required %0d",
                 f, got_q.size() - got_base, exp_q.size());
      end
      foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[got_base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_entry[%0d][%0d]: got %h, required %h", f, i, got_q[got_base + i], exp_q[i]);
        end
      end
      send_term();
      step();
      n_checks++;
      if (done !== 1'b1 || byte_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_done_hold[%0d]: done=%b valid=%b in_ready=%b overflow=%b, required 1 0 1 0",
                 f, done, byte_valid, in_ready, overflow);
      end
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_partial_flush();
    test_empty_tail();
    test_backpressure();
    test_term_on_byte();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
